branch_redirect_ctrl: RTL

Sequences control-flow redirects from the EX-stage branch unit and the trap path into fetch.
- Turns a resolved taken branch/jump, or a trap request, into a valid/ready redirect to the fetch stage.
- Kills wrong-path instructions in IF/ID and ID/EX until fetch has accepted the new PC and in-flight fetch returns have drained.
- Keeps branch statistics counters for the performance CSRs.

---
 rtl/branch_redirect_ctrl_pkg.sv | 23 ++
 rtl/branch_redirect_ctrl_br_stat_counters.sv | 25 ++
 rtl/branch_redirect_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types for the fetch-redirect controller: branch-unit bus, redirect
// bundle and controller FSM states.
package branch_redirect_ctrl_pkg;

  localparam int unsigned REDIR_SQUASH_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE,
    REDIR,
    SQUASH
  } redir_state_t;

  typedef struct packed {
    logic        is_taken;
    logic [31:0] branch_target;
  } br_cntrl_bus_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
  } redir_bus_t;

endpackage

// File: rtl/branch_redirect_ctrl_br_stat_counters.sv
// Free-running branch statistics for the performance CSRs: resolved branches
// and taken redirects, both wrapping modulo 2^CNT_W.
module br_stat_counters #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             br_inc_i,
  input  logic             taken_inc_i,
  output logic [CNT_W-1:0] br_cnt_o,
  output logic [CNT_W-1:0] taken_cnt_o
);

  // Wrap-around is intentional; the CSR reader handles overflow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      br_cnt_o    <= '0;
      taken_cnt_o <= '0;
    end else begin
      if (br_inc_i)    br_cnt_o    <= br_cnt_o + CNT_W'(1);
      if (taken_inc_i) taken_cnt_o <= taken_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Turns taken branches and trap requests into a valid/ready redirect to fetch,
// and squashes wrong-path work until fetch has drained.
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int unsigned SQUASH_CYCLES = REDIR_SQUASH_DEFAULT,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             br_valid_i,
  input  br_cntrl_bus_t    br_bus_i,
  input  logic             trap_req_i,
  input  logic [31:0]      trap_target_i,
  input  logic             fetch_ready_i,
  output logic             redir_valid_o,
  output logic [31:0]      redir_pc_o,
  output logic             flush_ifid_o,
  output logic             flush_idex_o,
  output logic             stall_ex_o,
  output logic             misalign_o,
  output logic [CNT_W-1:0] br_cnt_o,
  output logic [CNT_W-1:0] taken_cnt_o
);

  localparam logic [2:0] SQUASH_INIT = 3'(SQUASH_CYCLES);

  redir_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [2:0]   squash_q, squash_d;
  logic         misalign_q, misalign_d;
  logic         br_take, br_bad;
  logic         br_inc, taken_inc, early_flush;
  redir_bus_t   redir;

  assign br_take = br_valid_i & br_bus_i.is_taken & (br_bus_i.branch_target[1:0] == 2'b00);
  assign br_bad  = br_valid_i & br_bus_i.is_taken & (br_bus_i.branch_target[1:0] != 2'b00);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      squash_q   <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      squash_q   <= squash_d;
      misalign_q <= misalign_d;
    end
  end

  // A trap always wins; while a redirect is outstanding the EX branch is wrong-path.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    squash_d    = squash_q;
    misalign_d  = 1'b0;
    br_inc      = 1'b0;
    taken_inc   = 1'b0;
    early_flush = 1'b0;
    case (state_q)
      IDLE: begin
        if (trap_req_i) begin
          pc_d        = trap_target_i;
          state_d     = REDIR;
          early_flush = 1'b1;
        end else begin
          br_inc = br_valid_i;
          if (br_take) begin
            pc_d        = br_bus_i.branch_target;
            taken_inc   = 1'b1;
            state_d     = REDIR;
            early_flush = 1'b1;
          end else if (br_bad) begin
            misalign_d = 1'b1;
          end
        end
      end
      REDIR: begin
        // With fetch_ready the old PC transfers this cycle and the trap PC follows.
        if (trap_req_i) begin
          pc_d = trap_target_i;
        end else if (fetch_ready_i) begin
          if (SQUASH_INIT == 3'd0) begin
            state_d = IDLE;
          end else begin
            state_d  = SQUASH;
            squash_d = SQUASH_INIT;
          end
        end
      end
      SQUASH: begin
        if (trap_req_i) begin
          pc_d     = trap_target_i;
          state_d  = REDIR;
          squash_d = '0;
        end else if (squash_q <= 3'd1) begin
          state_d  = IDLE;
          squash_d = '0;
        end else begin
          squash_d = squash_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign redir.valid = (state_q == REDIR);
  assign redir.pc    = pc_q;

  assign redir_valid_o = redir.valid;
  assign redir_pc_o    = redir.pc;
  assign stall_ex_o    = redir.valid;
  assign misalign_o    = misalign_q;
  // Same-cycle flush keeps wrong-path instructions from advancing past the branch.
  assign flush_ifid_o  = redir.valid | (state_q == SQUASH) | (early_flush & ~rst_i);
  assign flush_idex_o  = redir.valid | (early_flush & ~rst_i);

  br_stat_counters #(
    .CNT_W(CNT_W)
  ) u_stats (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .br_inc_i    (br_inc),
    .taken_inc_i (taken_inc),
    .br_cnt_o    (br_cnt_o),
    .taken_cnt_o (taken_cnt_o)
  );

endmodule
